// File: rtl/ddr4_mr_train.sv
// rtl/ddr4_mr_train.sv - DDR4 multi-rank read-training controller with integrated per-tap fine sweep
module ddr4_mr_train #(
  parameter int GROUPS             = 4,
  parameter int RANKS              = 2,
  parameter int DELAY_TAPS         = 32,
  parameter int SETTLE_CYCLES      = 4,
  parameter int SAMPLES_PER_TAP    = 8,
  parameter int PASS_THRESHOLD     = 7,
  parameter int MIN_WINDOW         = 4,
  parameter int VALIDATION_SAMPLES = 16,
  parameter int MAX_VAL_FAILURES   = 1,
  parameter int MAX_RETRIES        = 3,
  parameter int COARSE_STEPS       = 8,
  localparam int TAP_W    = $clog2(DELAY_TAPS),
  localparam int RANK_W   = (RANKS > 1) ? $clog2(RANKS) : 1,
  localparam int COARSE_W = (COARSE_STEPS > 1) ? $clog2(COARSE_STEPS) : 1,
  localparam int RETRY_W  = $clog2(MAX_RETRIES + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_training,
  input  logic                      drift_detected,
  input  logic [GROUPS-1:0]         read_ok,
  output logic [RANK_W-1:0]         rank_sel,
  output logic [COARSE_W-1:0]       coarse_sel,
  output logic [GROUPS*TAP_W-1:0]   delay_tap,
  output logic                      busy,
  output logic                      locked,
  output logic                      training_done,
  output logic                      training_failed,
  output logic [RETRY_W-1:0]        retry_count,
  output logic [GROUPS-1:0]         group_fail
);

  localparam int CNT_W   = $clog2(SAMPLES_PER_TAP + 1);
  localparam int VF_W    = $clog2(VALIDATION_SAMPLES + 1);
  localparam int CYC_A   = (SETTLE_CYCLES > SAMPLES_PER_TAP) ? SETTLE_CYCLES : SAMPLES_PER_TAP;
  localparam int CYC_MAX = (CYC_A > VALIDATION_SAMPLES) ? CYC_A : VALIDATION_SAMPLES;
  localparam int CYC_W   = $clog2(CYC_MAX + 1);

  localparam logic [CYC_W-1:0]    SETTLE_LAST = CYC_W'(SETTLE_CYCLES - 1);
  localparam logic [CYC_W-1:0]    SAMPLE_LAST = CYC_W'(SAMPLES_PER_TAP - 1);
  localparam logic [CYC_W-1:0]    VAL_LAST    = CYC_W'(VALIDATION_SAMPLES - 1);
  localparam logic [CNT_W-1:0]    PASS_C      = CNT_W'(PASS_THRESHOLD);
  localparam logic [TAP_W:0]      MIN_LEN     = (TAP_W + 1)'(MIN_WINDOW);
  localparam logic [TAP_W-1:0]    TAP_LAST    = TAP_W'(DELAY_TAPS - 1);
  localparam logic [VF_W-1:0]     VF_MAX      = VF_W'(MAX_VAL_FAILURES);
  localparam logic [RANK_W-1:0]   RANK_LAST   = RANK_W'(RANKS - 1);
  localparam logic [RETRY_W-1:0]  RETRY_MAX   = RETRY_W'(MAX_RETRIES);
  localparam logic [COARSE_W-1:0] COARSE_LAST = COARSE_W'(COARSE_STEPS - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_RANK_INIT, S_SETTLE, S_SAMPLE, S_EVAL, S_CENTER,
    S_VALIDATE, S_RANK_NEXT, S_RETRY, S_DONE, S_FAIL
  } state_t;

  state_t                    state_q, state_d;
  logic [RANK_W-1:0]         rank_q, rank_d;
  logic [COARSE_W-1:0]       coarse_q, coarse_d;
  logic [TAP_W-1:0]          sweep_q, sweep_d;
  logic [CYC_W-1:0]          cyc_q, cyc_d;
  logic [VF_W-1:0]           vfail_q, vfail_d;
  logic [RETRY_W-1:0]        retry_q, retry_d;
  logic                      busy_q, busy_d;
  logic                      locked_q, locked_d;
  logic                      done_q, done_d;
  logic                      failed_q, failed_d;
  logic [GROUPS-1:0]         gfail_q, gfail_d;
  logic [GROUPS*TAP_W-1:0]   hold_q, tap_v;
  logic [CNT_W-1:0]          cnt_q [GROUPS];
  logic [CNT_W-1:0]          cnt_d [GROUPS];
  logic [TAP_W-1:0]          run_start_q [GROUPS];
  logic [TAP_W-1:0]          run_start_d [GROUPS];
  logic [TAP_W:0]            run_len_q [GROUPS];
  logic [TAP_W:0]            run_len_d [GROUPS];
  logic [TAP_W-1:0]          best_start_q [GROUPS];
  logic [TAP_W-1:0]          best_start_d [GROUPS];
  logic [TAP_W:0]            best_len_q [GROUPS];
  logic [TAP_W:0]            best_len_d [GROUPS];
  logic [TAP_W-1:0]          final_q [RANKS][GROUPS];
  logic [TAP_W-1:0]          final_d [RANKS][GROUPS];

  logic [TAP_W-1:0]          start_v;
  logic [TAP_W:0]            len_v;
  logic [VF_W-1:0]           vf_v;
  logic                      any_fail_v;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Datapath registers: counters, window tracking, stored taps and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rank_q   <= '0;
      coarse_q <= '0;
      sweep_q  <= '0;
      cyc_q    <= '0;
      vfail_q  <= '0;
      retry_q  <= '0;
      busy_q   <= 1'b0;
      locked_q <= 1'b0;
      done_q   <= 1'b0;
      failed_q <= 1'b0;
      gfail_q  <= '0;
      hold_q   <= '0;
      for (int g = 0; g < GROUPS; g++) begin
        cnt_q[g]        <= '0;
        run_start_q[g]  <= '0;
        run_len_q[g]    <= '0;
        best_start_q[g] <= '0;
        best_len_q[g]   <= '0;
        for (int r = 0; r < RANKS; r++) final_q[r][g] <= '0;
      end
    end else begin
      rank_q       <= rank_d;
      coarse_q     <= coarse_d;
      sweep_q      <= sweep_d;
      cyc_q        <= cyc_d;
      vfail_q      <= vfail_d;
      retry_q      <= retry_d;
      busy_q       <= busy_d;
      locked_q     <= locked_d;
      done_q       <= done_d;
      failed_q     <= failed_d;
      gfail_q      <= gfail_d;
      hold_q       <= tap_v;
      cnt_q        <= cnt_d;
      run_start_q  <= run_start_d;
      run_len_q    <= run_len_d;
      best_start_q <= best_start_d;
      best_len_q   <= best_len_d;
      final_q      <= final_d;
    end
  end

  // Next-state and datapath update logic
  always_comb begin
    state_d      = state_q;
    rank_d       = rank_q;
    coarse_d     = coarse_q;
    sweep_d      = sweep_q;
    cyc_d        = cyc_q;
    vfail_d      = vfail_q;
    retry_d      = retry_q;
    busy_d       = busy_q;
    locked_d     = locked_q;
    done_d       = done_q;
    failed_d     = failed_q;
    gfail_d      = gfail_q;
    cnt_d        = cnt_q;
    run_start_d  = run_start_q;
    run_len_d    = run_len_q;
    best_start_d = best_start_q;
    best_len_d   = best_len_q;
    final_d      = final_q;
    start_v      = '0;
    len_v        = '0;
    vf_v         = '0;
    any_fail_v   = 1'b0;

    case (state_q)
      S_IDLE, S_FAIL: begin
        if (start_training) begin
          retry_d  = '0;
          done_d   = 1'b0;
          failed_d = 1'b0;
          locked_d = 1'b0;
          rank_d   = '0;
          busy_d   = 1'b1;
          state_d  = S_RANK_INIT;
        end
      end
      S_RANK_INIT: begin
        sweep_d = '0;
        cyc_d   = '0;
        for (int g = 0; g < GROUPS; g++) begin
          run_start_d[g]  = '0;
          run_len_d[g]    = '0;
          best_start_d[g] = '0;
          best_len_d[g]   = '0;
        end
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        for (int g = 0; g < GROUPS; g++) cnt_d[g] = '0;
        if (cyc_q == SETTLE_LAST) begin
          cyc_d   = '0;
          state_d = S_SAMPLE;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      S_SAMPLE: begin
        for (int g = 0; g < GROUPS; g++)
          if (read_ok[g]) cnt_d[g] = cnt_q[g] + 1'b1;
        if (cyc_q == SAMPLE_LAST) begin
          cyc_d   = '0;
          state_d = S_EVAL;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      S_EVAL: begin
        for (int g = 0; g < GROUPS; g++) begin
          if (cnt_q[g] >= PASS_C) begin
            start_v        = (run_len_q[g] == '0) ? sweep_q : run_start_q[g];
            len_v          = run_len_q[g] + 1'b1;
            run_start_d[g] = start_v;
            run_len_d[g]   = len_v;
            // Strict compare: an equal-length later run never displaces the earlier one
            if (len_v > best_len_q[g]) begin
              best_start_d[g] = start_v;
              best_len_d[g]   = len_v;
            end
          end else begin
            run_len_d[g] = '0;
          end
        end
        cyc_d = '0;
        if (sweep_q == TAP_LAST) begin
          state_d = S_CENTER;
        end else begin
          sweep_d = sweep_q + 1'b1;
          state_d = S_SETTLE;
        end
      end
      S_CENTER: begin
        for (int g = 0; g < GROUPS; g++) begin
          gfail_d[g] = (best_len_q[g] < MIN_LEN);
          if (best_len_q[g] < MIN_LEN) any_fail_v = 1'b1;
        end
        if (any_fail_v) begin
          state_d = S_RETRY;
        end else begin
          for (int g = 0; g < GROUPS; g++)
            final_d[rank_q][g] = TAP_W'({1'b0, best_start_q[g]} + ((best_len_q[g] - 1'b1) >> 1));
          cyc_d   = '0;
          vfail_d = '0;
          state_d = S_VALIDATE;
        end
      end
      S_VALIDATE: begin
        vf_v    = vfail_q + VF_W'(read_ok != {GROUPS{1'b1}});
        vfail_d = vf_v;
        if (cyc_q == VAL_LAST) begin
          cyc_d   = '0;
          state_d = (vf_v <= VF_MAX) ? S_RANK_NEXT : S_RETRY;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      S_RANK_NEXT: begin
        if (rank_q == RANK_LAST) begin
          done_d   = 1'b1;
          locked_d = 1'b1;
          busy_d   = 1'b0;
          state_d  = S_DONE;
        end else begin
          rank_d  = rank_q + 1'b1;
          state_d = S_RANK_INIT;
        end
      end
      S_RETRY: begin
        if (retry_q == RETRY_MAX) begin
          failed_d = 1'b1;
          busy_d   = 1'b0;
          locked_d = 1'b0;
          state_d  = S_FAIL;
        end else begin
          retry_d  = retry_q + 1'b1;
          coarse_d = (coarse_q == COARSE_LAST) ? '0 : coarse_q + 1'b1;
          state_d  = S_RANK_INIT;
        end
      end
      S_DONE: begin
        // Drift and start are one restart request; coarse setting is retained
        if (drift_detected || start_training) begin
          locked_d = 1'b0;
          done_d   = 1'b0;
          retry_d  = '0;
          rank_d   = '0;
          busy_d   = 1'b1;
          state_d  = S_RANK_INIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Delay-line drive: sweep tap while sweeping, trained taps while validating or locked, else hold
  always_comb begin
    tap_v = hold_q;
    case (state_q)
      S_RANK_INIT: tap_v = '0;
      S_SETTLE, S_SAMPLE, S_EVAL:
        for (int g = 0; g < GROUPS; g++) tap_v[g*TAP_W +: TAP_W] = sweep_q;
      S_VALIDATE, S_DONE:
        for (int g = 0; g < GROUPS; g++) tap_v[g*TAP_W +: TAP_W] = final_q[rank_q][g];
      default: tap_v = hold_q;
    endcase
  end

  assign delay_tap       = tap_v;
  assign rank_sel        = rank_q;
  assign coarse_sel      = coarse_q;
  assign busy            = busy_q;
  assign locked          = locked_q;
  assign training_done   = done_q;
  assign training_failed = failed_q;
  assign retry_count     = retry_q;
  assign group_fail      = gfail_q;

endmodule

// File: doc/ddr4_mr_train.md
Name: ddr4_mr_train

Overview:
- Next-generation DDR4 PHY read-training controller.
- Trains RANKS ranks × GROUPS byte groups with an integrated per-tap fine sweep, so no external fine engine is needed.
- Detects the widest passing window per group, centres each group independently, validates, then retries with coarse advance.
- Sits between the PHY delay lines and the memory controller; fail state recoverable via new start, drift retrains all ranks.

Parameters:
- GROUPS, 4, byte groups, each with an independent delay line
- RANKS, 2, ranks trained sequentially
- DELAY_TAPS, 32, fine taps per line (TAP_W = $clog2(DELAY_TAPS))
- SETTLE_CYCLES, 4, wait cycles after each tap change
- SAMPLES_PER_TAP, 8, read_ok samples per tap
- PASS_THRESHOLD, 7, passing samples needed for a tap to pass
- MIN_WINDOW, 4, minimum best-window length per group
- VALIDATION_SAMPLES, 16, validation cycles per rank
- MAX_VAL_FAILURES, 1, tolerated failing validation cycles
- MAX_RETRIES, 3, retries per training run
- COARSE_STEPS, 8, coarse settings; coarse_sel wraps

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start_training  in  1  start pulse; ignored while busy
- drift_detected  in  1  retrain request; honoured only in DONE
- read_ok  in  GROUPS  per-group read compare pass
- rank_sel  out  $clog2(RANKS) (min 1)  rank under training or held
- coarse_sel  out  $clog2(COARSE_STEPS)  coarse delay select
- delay_tap  out  GROUPS*TAP_W  flat per-group tap; group g at [g*TAP_W +: TAP_W]
- busy  out  1  training in progress
- locked  out  1  all ranks trained and validated
- training_done  out  1  success, sticky until restart
- training_failed  out  1  failure, sticky until restart
- retry_count  out  $clog2(MAX_RETRIES+1)  retries used this run
- group_fail  out  GROUPS  groups whose window < MIN_WINDOW at the last centring

Behaviour:
- Reset values: all outputs 0; state IDLE; all stored final taps 0.
- Sweep timing per tap:
  - SETTLE lasts SETTLE_CYCLES cycles; on entry all groups are driven to sweep_tap.
  - SAMPLE lasts SAMPLES_PER_TAP cycles; each cycle increments a per-group counter where read_ok[g] = 1.
  - EVAL lasts 1 cycle.
  - Each tap therefore costs SETTLE_CYCLES + SAMPLES_PER_TAP + 1 cycles.
- States:
  - IDLE: on start_training, clear retry_count, done, failed and locked; set rank_sel = 0, busy = 1; go to RANK_INIT.
  - RANK_INIT (1 cycle): sweep_tap = 0; clear per-group run_start, run_len, best_start and best_len; go to SETTLE.
  - SETTLE → SAMPLE → EVAL.
  - EVAL: tap passes for group g when count ≥ PASS_THRESHOLD.
    - On pass: if run_len == 0 then run_start = sweep_tap; run_len++; if run_len > best_len (strict), copy the run to best, so ties keep the earliest window.
    - On fail: run_len = 0.
    - Then if sweep_tap == DELAY_TAPS-1 go to CENTER, else sweep_tap++ and go to SETTLE.
  - CENTER (1 cycle):
    - group_fail[g] = (best_len < MIN_WINDOW).
    - If any group fails, go to RETRY.
    - Otherwise store final_tap[rank_sel][g] = best_start + ((best_len-1) >> 1), computed in TAP_W+1 bits and always < DELAY_TAPS; go to VALIDATE.
  - VALIDATE: runs VALIDATION_SAMPLES cycles, counting cycles where read_ok ≠ all-ones.
    - At the end: failures ≤ MAX_VAL_FAILURES → RANK_NEXT, else RETRY.
  - RANK_NEXT: if rank_sel == RANKS-1, go to DONE; else rank_sel++ and go to RANK_INIT.
    - retry_count is not cleared between ranks.
  - RETRY: if retry_count == MAX_RETRIES, go to FAIL.
    - Otherwise retry_count++, coarse_sel = (coarse_sel+1) mod COARSE_STEPS, and restart the same rank at RANK_INIT.
  - DONE: training_done = 1, locked = 1, busy = 0.
    - drift_detected → locked = 0, done = 0, retry_count = 0, rank_sel = 0, go to RANK_INIT; coarse_sel is kept.
    - start_training in DONE behaves the same as drift.
    - Both asserted together cause a single restart.
  - FAIL: training_failed = 1, busy = 0, locked = 0; sticky. start_training restarts exactly as from IDLE.
- delay_tap drive:
  - RANK_INIT/SETTLE/SAMPLE/EVAL: all groups = sweep_tap.
  - VALIDATE/DONE: final_tap[rank_sel].
  - Elsewhere: hold.
- drift_detected outside DONE is ignored; start_training while busy is ignored.
- Reset mid-operation returns to IDLE immediately with all outputs 0; no partial result is retained.
- Counters are sized so the counts SETTLE_CYCLES, SAMPLES_PER_TAP and VALIDATION_SAMPLES do not overflow.

Test Plan:
- Defaults, all groups pass taps 10..20 for both ranks → each group taps to 15; done=1, locked=1, retry_count=0 at cycle 2 × (1 + 32×13 + 1 + 16 + 1) + 1.
- Group 2 passes 3..5 and 12..14 → tie keeps the earliest window; group 2 final tap = 4; other groups unaffected.
- Group 1 passes only 8..10 (len 3) → group_fail = 4'b0010; RETRY with coarse_sel = 1, retry_count = 1. Four failing sweeps → training_failed = 1, retry_count = 3.
- Validation with 2 failing cycles → RETRY; with exactly 1 failing cycle → proceeds to rank 1.
- Trained, then drift_detected and start_training pulsed in the same cycle → single retrain from rank 0, locked drops the next cycle, coarse_sel unchanged.
- rst_n asserted mid-sweep at tap 17 → all outputs 0 immediately; a new start sweeps from tap 0.
